bsg_axil_stream_endpoint: RTL
=============================

# bsg_axil_stream_endpoint

AXI4-Lite slave that terminates the DMA engine's master port (m_axil) and turns its word traffic into a pair of ready/valid streams. DMA writes to the data address push words into an outbound stream FIFO. DMA reads from the data address pop words from an inbound stream FIFO. A status address reports both FIFO occupancies, so the DMA, or host software, can move data between memory and a streaming accelerator without a memory-mapped buffer.

## Interface
Parameters:
- axil_data_width_p, 32, AXI-Lite and stream word width (32 or 64)
- axil_addr_width_p, 32, AXI-Lite address width
- els_p, 16, depth of each FIFO; 2 <= els_p <= 32767

Ports:
- clk_i  in  1  single clock
- reset_i  in  1  synchronous reset, active-high
- s_axil_awaddr_i / awprot_i / awvalid_i  in  addr_width / 3 / 1  write address (awprot ignored)
- s_axil_awready_o  out  1
- s_axil_wdata_i / wstrb_i / wvalid_i  in  data_width / data_width/8 / 1  write data (wstrb ignored)
- s_axil_wready_o  out  1
- s_axil_bresp_o / bvalid_o  out  2 / 1  write response
- s_axil_bready_i  in  1
- s_axil_araddr_i / arprot_i / arvalid_i  in  addr_width / 3 / 1  read address (arprot ignored)
- s_axil_arready_o  out  1
- s_axil_rdata_o / rresp_o / rvalid_o  out  data_width / 2 / 1  read data
- s_axil_rready_i  in  1
- data_o / v_o  out  data_width / 1  outbound stream
- ready_and_i  in  1  outbound stream consumer ready
- data_i / v_i  in  data_width / 1  inbound stream
- ready_and_o  out  1  inbound FIFO not full

## Operation
- Address decode uses only bit 2. addr[2]=0 selects DATA; addr[2]=1 selects STATUS. All other bits are ignored, so the two registers alias across the address space.
- STATUS read word:
  - bits[15:0] = inbound FIFO occupancy
  - bits[31:16] = outbound FIFO occupancy
  - remaining bits are 0
- Write FSM, states e_wr_idle and e_wr_resp:
  - In e_wr_idle, awready_o and wready_o are asserted together, in the same cycle, iff awvalid_i & wvalid_i & (STATUS target | outbound FIFO not full).
  - AW and W are accepted only as a pair. One alone is never accepted.
  - On acceptance: a DATA write pushes wdata and records bresp=OKAY (2'b00). A STATUS write is dropped and records bresp=SLVERR (2'b10).
  - The FSM then moves to e_wr_resp.
  - e_wr_resp: bvalid_o=1 and bresp_o is held stable. On bready_i the FSM returns to e_wr_idle. No new AW/W is accepted while in e_wr_resp.
- Read FSM, states e_rd_idle and e_rd_resp:
  - In e_rd_idle, arready_o = arvalid_i & (STATUS target | inbound FIFO not empty).
  - A DATA read stalls (arready_o low) while the inbound FIFO is empty. It never returns an error.
  - On acceptance the FSM registers rdata: the popped FIFO head for DATA, or the status word for STATUS. rresp is always OKAY. The FSM moves to e_rd_resp.
  - e_rd_resp: rvalid_o=1, and rdata/rresp are held stable. On rready_i the FSM returns to e_rd_idle.
- The write and read FSMs run independently; one write and one read may both be in flight.
- Outbound stream: v_o = outbound FIFO not empty and data_o = its head. A pop occurs when v_o & ready_and_i.
- Inbound stream: a push occurs when v_i & ready_and_o.
- FIFO full is judged on the registered count. There is no same-cycle bypass:
  - A full outbound FIFO blocks the AW/W accept even when a stream pop happens in that cycle.
  - Likewise, an empty inbound FIFO blocks an AR accept even when v_i is high in that cycle.
- Simultaneous push and pop on a non-empty, non-full FIFO is allowed; occupancy is unchanged.
- STATUS sampling:
  - The status value is the occupancy registered before the accept edge.
  - On the same edge as a STATUS read, a concurrent write push or stream push/pop is not reflected in the value returned.

## Timing
- Reset values while reset_i is high and on the first cycle after it falls:
  - awready_o, wready_o, arready_o, bvalid_o, rvalid_o, v_o and ready_and_o are all 0.
  - bresp_o, rresp_o and rdata_o are 0.
  - Both FIFOs are empty and both FSMs are idle.
- Reset mid-transaction abandons the transaction: a pending B or R beat is dropped and FIFO contents are lost.
- Write latency: bvalid_o rises 1 cycle after the AW/W accept edge. Back-to-back writes sustain 1 word per 2 cycles when bready_i is held high.
- Read latency: rvalid_o rises 1 cycle after the AR accept edge. Throughput is 1 word per 2 cycles.
- Stream latency: a word pushed at edge N is visible on data_o/v_o, or poppable by AR, from cycle N+1.
- Occupancy counters are $clog2(els_p+1) bits wide and zero-extended into their 16-bit status fields.

## Structure
- Package bsg_axil_stream_endpoint_pkg holds:
  - the write and read FSM state enums
  - localparams for the DATA/STATUS address bit (bit 2)
  - the OKAY/SLVERR resp codes
  - the status field offsets (0 and 16)
- Sub-module: the existing bsg_fifo_1r1w_small, instantiated twice (outbound and inbound) with els_p depth. Occupancy counters live in this block.

## Test plan
- After reset, write 0xA5A5_0001 to addr 0x0 with ready_and_i=1 -> bvalid/bresp=OKAY 1 cycle after accept; data_o=0xA5A5_0001 with v_o=1 the cycle after accept.
- Hold ready_and_i=0 and issue 17 writes with els_p=16 -> 16 accepted; the 17th holds awready/wready low until one pop, then is accepted the following cycle.
- Write to addr 0x4 -> bresp=SLVERR, no push.
- Push 3 words on data_i/v_i, then read 0x4 -> rdata=0x0000_0003. Read 0x0 three times -> words returned in order. Issue a fourth read -> arready_o stays low until a new v_i word arrives, then that word is returned.
- Hold bready_i/rready_i low for 5 cycles -> bvalid/rvalid and data stay stable, and no further accept occurs.
- Assert reset_i with a write response pending and 4 words queued -> next cycle bvalid_o=0, v_o=0, and status reads 0.

Source files
------------

// File: rtl/bsg_axil_stream_endpoint_pkg.sv
// Shared types and constants for the AXI-Lite stream endpoint.
// FSM states, address decode bit, response codes, status layout.
package bsg_axil_stream_endpoint_pkg;

    typedef enum logic {
        e_wr_idle = 1'b0,
        e_wr_resp = 1'b1
    } wr_state_e;

    typedef enum logic {
        e_rd_idle = 1'b0,
        e_rd_resp = 1'b1
    } rd_state_e;

    localparam int unsigned addr_sel_bit_lp = 2;

    localparam logic [1:0] resp_okay_lp   = 2'b00;
    localparam logic [1:0] resp_slverr_lp = 2'b10;

    localparam int unsigned status_in_lsb_lp  = 0;
    localparam int unsigned status_out_lsb_lp = 16;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO with registered occupancy count.
// Full/empty come from the registered count; no same-cycle bypass.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 32,
    parameter int els_p   = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    output logic                       ready_o,
    input  logic [width_p-1:0]         data_i,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       yumi_i,
    output logic [$clog2(els_p+1)-1:0] count_o
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p+1);

    logic [width_p-1:0]  r_mem [els_p];
    logic [ptr_w_lp-1:0] r_rptr;
    logic [ptr_w_lp-1:0] r_wptr;
    logic [cnt_w_lp-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign ready_o = (r_count != cnt_w_lp'(els_p));
    assign v_o     = (r_count != '0);
    assign data_o  = r_mem[r_rptr];
    assign count_o = r_count;

    assign w_push = v_i & ready_o;
    assign w_pop  = yumi_i & v_o;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p-1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (w_push & ~w_pop) begin
                r_count <= r_count + cnt_w_lp'(1);
            end else if (w_pop & ~w_push) begin
                r_count <= r_count - cnt_w_lp'(1);
            end
        end
    end

endmodule

// File: rtl/bsg_axil_stream_endpoint.sv
// AXI-Lite slave bridging DMA word traffic to outbound/inbound streams.
// addr[2] selects DATA (FIFO push/pop) or STATUS (both occupancies).
module bsg_axil_stream_endpoint
    import bsg_axil_stream_endpoint_pkg::*;
#(
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32,
    parameter int els_p             = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,

    input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
    input  logic [2:0]                     s_axil_awprot_i,
    input  logic                           s_axil_awvalid_i,
    output logic                           s_axil_awready_o,

    input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
    input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
    input  logic                           s_axil_wvalid_i,
    output logic                           s_axil_wready_o,

    output logic [1:0]                     s_axil_bresp_o,
    output logic                           s_axil_bvalid_o,
    input  logic                           s_axil_bready_i,

    input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
    input  logic [2:0]                     s_axil_arprot_i,
    input  logic                           s_axil_arvalid_i,
    output logic                           s_axil_arready_o,

    output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
    output logic [1:0]                     s_axil_rresp_o,
    output logic                           s_axil_rvalid_o,
    input  logic                           s_axil_rready_i,

    output logic [axil_data_width_p-1:0]   data_o,
    output logic                           v_o,
    input  logic                           ready_and_i,

    input  logic [axil_data_width_p-1:0]   data_i,
    input  logic                           v_i,
    output logic                           ready_and_o
);

    localparam int cnt_w_lp = $clog2(els_p+1);

    wr_state_e r_wr_state;
    rd_state_e r_rd_state;

    logic [1:0]                   r_bresp;
    logic [axil_data_width_p-1:0] r_rdata;
    logic                         r_live;

    logic                         w_aw_status;
    logic                         w_ar_status;
    logic                         w_wr_accept;
    logic                         w_ar_accept;
    logic                         w_out_ready;
    logic                         w_in_valid;
    logic                         w_in_ready;
    logic [axil_data_width_p-1:0] w_in_data;
    logic [cnt_w_lp-1:0]          w_out_count;
    logic [cnt_w_lp-1:0]          w_in_count;
    logic [axil_data_width_p-1:0] w_status;
    logic                         w_unused;

    assign w_unused = ^{s_axil_awprot_i, s_axil_arprot_i, s_axil_wstrb_i,
                        s_axil_awaddr_i, s_axil_araddr_i};

    assign w_aw_status = s_axil_awaddr_i[addr_sel_bit_lp];
    assign w_ar_status = s_axil_araddr_i[addr_sel_bit_lp];

    // Keeps every ready low on the first cycle out of reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    assign w_wr_accept = r_live & ~reset_i
                       & (r_wr_state == e_wr_idle)
                       & s_axil_awvalid_i & s_axil_wvalid_i
                       & (w_aw_status | w_out_ready);

    assign w_ar_accept = r_live & ~reset_i
                       & (r_rd_state == e_rd_idle)
                       & s_axil_arvalid_i
                       & (w_ar_status | w_in_valid);

    assign s_axil_awready_o = w_wr_accept;
    assign s_axil_wready_o  = w_wr_accept;
    assign s_axil_arready_o = w_ar_accept;

    assign s_axil_bvalid_o = (r_wr_state == e_wr_resp);
    assign s_axil_bresp_o  = r_bresp;
    assign s_axil_rvalid_o = (r_rd_state == e_rd_resp);
    assign s_axil_rdata_o  = r_rdata;
    assign s_axil_rresp_o  = resp_okay_lp;

    assign ready_and_o = r_live & ~reset_i & w_in_ready;

    always_comb begin
        w_status = '0;
        w_status[status_in_lsb_lp  +: 16] = 16'(w_in_count);
        w_status[status_out_lsb_lp +: 16] = 16'(w_out_count);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_state <= e_wr_idle;
            r_bresp    <= resp_okay_lp;
        end else begin
            unique case (r_wr_state)
                e_wr_idle: begin
                    if (w_wr_accept) begin
                        r_wr_state <= e_wr_resp;
                        r_bresp    <= w_aw_status ? resp_slverr_lp : resp_okay_lp;
                    end
                end
                e_wr_resp: begin
                    if (s_axil_bready_i) begin
                        r_wr_state <= e_wr_idle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rd_state <= e_rd_idle;
            r_rdata    <= '0;
        end else begin
            unique case (r_rd_state)
                e_rd_idle: begin
                    if (w_ar_accept) begin
                        r_rd_state <= e_rd_resp;
                        r_rdata    <= w_ar_status ? w_status : w_in_data;
                    end
                end
                e_rd_resp: begin
                    if (s_axil_rready_i) begin
                        r_rd_state <= e_rd_idle;
                    end
                end
            endcase
        end
    end

    bsg_fifo_1r1w_small #(
        .width_p (axil_data_width_p),
        .els_p   (els_p)
    ) u_out_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (w_wr_accept & ~w_aw_status),
        .ready_o (w_out_ready),
        .data_i  (s_axil_wdata_i),
        .v_o     (v_o),
        .data_o  (data_o),
        .yumi_i  (ready_and_i),
        .count_o (w_out_count)
    );

    bsg_fifo_1r1w_small #(
        .width_p (axil_data_width_p),
        .els_p   (els_p)
    ) u_in_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (v_i & ready_and_o),
        .ready_o (w_in_ready),
        .data_i  (data_i),
        .v_o     (w_in_valid),
        .data_o  (w_in_data),
        .yumi_i  (w_ar_accept & ~w_ar_status),
        .count_o (w_in_count)
    );

endmodule
